// File: rtl/pam_pkg.sv
// pam_pkg: shared constants and helpers for the PAM multiply scheduler.
//   NREQ        - number of requesters
//   ID_W        - requester index width
//   OP_W        - operand width (multiplicand / multiplier)
//   PROD_W      - product width
//   cnt_sat_max - ceiling of the completed-result counter
//   cnt_sat_inc - saturating increment used by the result counter
package pam_pkg;

    localparam int NREQ   = 4;
    localparam int ID_W   = 2;
    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    localparam logic [PROD_W-1:0] cnt_sat_max = 16'hFFFF;

    // Increment that sticks at cnt_sat_max instead of wrapping to zero.
    function automatic logic [PROD_W-1:0] cnt_sat_inc(input logic [PROD_W-1:0] v);
        logic [PROD_W-1:0] r;
        if (v == cnt_sat_max) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pam_approx_mul8_l4.sv
// pam_approx_mul8_l4: combinational 8x8 multiplier with an approximate mode.
//   x, y  - 8-bit operands
//   exact - 1: z = x*y, 0: approximate product
//   z     - 16-bit product
// The approximate mode keeps the full upper-nibble partial product of x and
// replaces the lower nibble's contribution with a handful of compensation bits
// that recover the most significant carries the lower nibble would produce.
module pam_approx_mul8_l4
    import pam_pkg::*;
(
    input  logic [OP_W-1:0]   x,
    input  logic [OP_W-1:0]   y,
    input  logic              exact,
    output logic [PROD_W-1:0] z
);

    logic [PROD_W-1:0] hi_part_s;
    logic              b8_s;
    logic              b9_a_s;
    logic              b10_s;
    logic              b9_b_s;
    logic              b9_c_s;
    logic [PROD_W-1:0] approx_s;

    // Approximate sum, exact product and mode select.
    always_comb begin
        hi_part_s = ({8'd0, y} * {12'd0, x[7:4]}) << 4;
        b8_s      = (x[0] & y[7]) | (x[1] & y[6]);
        b9_a_s    = (x[2] & y[6]) | (x[3] & y[5]);
        b10_s     = x[3] & y[7];
        b9_b_s    = (x[2] & y[7]) & (x[3] & y[6]);
        b9_c_s    = (x[2] & y[7]) | (x[3] & y[6]);
        // Sum wraps naturally in 16 bits.
        approx_s  = hi_part_s
                  + {7'd0, b8_s,   8'd0}
                  + {6'd0, b9_a_s, 9'd0}
                  + {5'd0, b10_s,  10'd0}
                  + {6'd0, b9_b_s, 9'd0}
                  + {6'd0, b9_c_s, 9'd0};
        if (exact) begin
            z = {8'd0, x} * {8'd0, y};
        end else begin
            z = approx_s;
        end
    end

endmodule

// File: rtl/pam_mul_sched.sv
// pam_mul_sched: round-robin scheduler feeding a 2-stage multiply pipeline.
//   clk, rst_n          - clock, asynchronous active-low reset
//   req_valid/req_ready - per-requester handshake (ready is one-hot or zero)
//   req_x, req_y        - packed 8-bit operands, requester i at [8i+7:8i]
//   cfg_exact           - exact/approximate select, captured with the operands
//   res_valid/res_ready - result handshake
//   res_z, res_id       - product and owning requester index
//   op_count            - saturating count of delivered results
// Stage 1 holds the granted operands; stage 2 holds the product. Stage 2 holds
// under backpressure and stage 1 stalls behind it.
module pam_mul_sched #(
    parameter int NREQ = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*pam_pkg::OP_W-1:0] req_x,
    input  logic [NREQ*pam_pkg::OP_W-1:0] req_y,
    input  logic                          cfg_exact,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [pam_pkg::PROD_W-1:0]    res_z,
    output logic [pam_pkg::ID_W-1:0]      res_id,
    output logic [pam_pkg::PROD_W-1:0]    op_count
);

    import pam_pkg::*;

    logic [ID_W-1:0]   rr_ptr_r;
    logic              s1_valid_r;
    logic [OP_W-1:0]   s1_x_r;
    logic [OP_W-1:0]   s1_y_r;
    logic [ID_W-1:0]   s1_id_r;
    logic              s1_exact_r;
    logic              res_valid_r;
    logic [PROD_W-1:0] res_z_r;
    logic [ID_W-1:0]   res_id_r;
    logic [PROD_W-1:0] op_count_r;

    logic              win_found_s;
    logic [ID_W-1:0]   win_id_s;
    logic              s2_adv_s;
    logic              s1_free_s;
    logic              req_fire_s;
    logic              res_fire_s;
    logic [OP_W-1:0]   sel_x_s;
    logic [OP_W-1:0]   sel_y_s;
    logic [PROD_W-1:0] prod_s;

    // Round-robin search from rr_ptr upward, grant gating and handshake decode.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            logic [ID_W-1:0] idx_v;
            idx_v = rr_ptr_r + ID_W'(k);
            if (!win_found_s && req_valid[idx_v]) begin
                win_found_s = 1'b1;
                win_id_s    = idx_v;
            end else begin
                win_found_s = win_found_s;
            end
        end
        s2_adv_s  = !res_valid_r || res_ready;
        s1_free_s = !s1_valid_r || s2_adv_s;
        // rst_n gating keeps ready low while reset is held, even though the
        // registers alone would already report the pipeline as free.
        if (rst_n && win_found_s && s1_free_s) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
        end else begin
            req_ready = {NREQ{1'b0}};
        end
        req_fire_s = |(req_valid & req_ready);
        res_fire_s = res_valid_r && res_ready;
        sel_x_s    = req_x[win_id_s*OP_W +: OP_W];
        sel_y_s    = req_y[win_id_s*OP_W +: OP_W];
    end

    // Stage 1 operand capture and round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r   <= 2'd0;
            s1_valid_r <= 1'b0;
            s1_x_r     <= 8'd0;
            s1_y_r     <= 8'd0;
            s1_id_r    <= 2'd0;
            s1_exact_r <= 1'b0;
        end else if (req_fire_s) begin
            rr_ptr_r   <= win_id_s + 2'd1;
            s1_valid_r <= 1'b1;
            s1_x_r     <= sel_x_s;
            s1_y_r     <= sel_y_s;
            s1_id_r    <= win_id_s;
            s1_exact_r <= cfg_exact;
        end else if (s2_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    pam_approx_mul8_l4 u_mul (
        .x     (s1_x_r),
        .y     (s1_y_r),
        .exact (s1_exact_r),
        .z     (prod_s)
    );

    // Stage 2 product register; frozen while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_z_r     <= 16'd0;
            res_id_r    <= 2'd0;
        end else if (s2_adv_s) begin
            res_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                res_z_r  <= prod_s;
                res_id_r <= s1_id_r;
            end else begin
                res_z_r  <= res_z_r;
                res_id_r <= res_id_r;
            end
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    // Saturating count of delivered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'd0;
        end else if (res_fire_s) begin
            op_count_r <= cnt_sat_inc(op_count_r);
        end else begin
            op_count_r <= op_count_r;
        end
    end

    assign res_valid = res_valid_r;
    assign res_z     = res_z_r;
    assign res_id    = res_id_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_pam_mul_sched.sv
// tb_pam_mul_sched: self-checking bench for pam_mul_sched.
// A negedge monitor keeps a transaction-level model (expected-result queue,
// round-robin pointer, saturating counter) and checks every cycle; directed
// sequences cover latency, fairness, backpressure, reset and saturation.
module tb_pam_mul_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'd0;
    logic [3:0]  req_ready;
    logic [31:0] req_x = 32'd0;
    logic [31:0] req_y = 32'd0;
    logic        cfg_exact = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [15:0] res_z;
    logic [1:0]  res_id;
    logic [15:0] op_count;

    int errors = 0;
    int checks = 0;

    pam_mul_sched #(.NREQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .cfg_exact (cfg_exact),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_z     (res_z),
        .res_id    (res_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Product from the arithmetic definition of both modes.
    function automatic logic [15:0] mdl_mul(input logic [7:0] x, input logic [7:0] y, input logic ex);
        int s;
        int xi;
        int yi;
        xi = x;
        yi = y;
        if (ex) begin
            s = xi * yi;
        end else begin
            s = yi * (xi / 16) * 16;
            s += int'((x[0] & y[7]) | (x[1] & y[6])) * 256;
            s += int'((x[2] & y[6]) | (x[3] & y[5])) * 512;
            s += int'(x[3] & y[7]) * 1024;
            s += int'((x[2] & y[7]) & (x[3] & y[6])) * 512;
            s += int'((x[2] & y[7]) | (x[3] & y[6])) * 512;
        end
        return 16'(s % 65536);
    endfunction

    typedef struct {
        logic [1:0]  id;
        logic [15:0] z;
    } res_t;

    res_t        exp_q[$];
    int          mdl_rr = 0;
    logic [15:0] mdl_cnt = 16'd0;
    bit          mon_en = 1'b0;
    bit          hold_prev = 1'b0;
    logic [15:0] prev_z;
    logic [1:0]  prev_id;

    // Transaction-level monitor.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            int         win;
            logic [3:0] exp_rdy;
            res_t       e;
            if (hold_prev) begin
                chk("hold_valid", {31'd0, res_valid}, 32'd1);
                chk("hold_z", {16'd0, res_z}, {16'd0, prev_z});
                chk("hold_id", {30'd0, res_id}, {30'd0, prev_id});
            end
            chk("op_count", {16'd0, op_count}, {16'd0, mdl_cnt});
            if (exp_q.size() == 0) chk("idle_valid", {31'd0, res_valid}, 32'd0);
            win = -1;
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && req_valid[(mdl_rr + k) % 4]) win = (mdl_rr + k) % 4;
            end
            // At most two results can be in flight; a full pipe accepts only
            // when the consumer drains this cycle.
            exp_rdy = (win >= 0 && (exp_q.size() < 2 || res_ready)) ? 4'(1 << win) : 4'd0;
            chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", {31'd0, res_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_z", {16'd0, res_z}, {16'd0, e.z});
                    chk("res_id", {30'd0, res_id}, {30'd0, e.id});
                    if (mdl_cnt != 16'hFFFF) mdl_cnt++;
                end
            end
            if (exp_rdy != 4'd0) begin
                e.id = 2'(win);
                e.z  = mdl_mul(req_x[win*8 +: 8], req_y[win*8 +: 8], cfg_exact);
                exp_q.push_back(e);
                mdl_rr = (win + 1) % 4;
            end
            hold_prev = res_valid && !res_ready;
            prev_z    = res_z;
            prev_id   = res_id;
        end
    end

    task automatic idle(input int n);
        @(posedge clk); #1;
        req_valid = 4'd0;
        res_ready = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    // One isolated request; checks the two-cycle latency explicitly.
    task automatic run_one(input string name, input logic [1:0] id, input logic [7:0] x,
                           input logic [7:0] y, input logic ex, input logic [15:0] expz);
        logic got;
        idle(3);
        #1;
        req_valid     = 4'd0;
        req_valid[id] = 1'b1;
        req_x[id*8 +: 8] = x;
        req_y[id*8 +: 8] = y;
        cfg_exact     = ex;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            @(negedge clk);
            got = req_ready[id];
        end
        if (!got) begin
            chk({name, "_grant"}, {31'd0, req_ready[id]}, 32'd1);
        end else begin
            @(posedge clk); #1;
            req_valid = 4'd0;
            chk({name, "_lat1"}, {31'd0, res_valid}, 32'd0);
            @(posedge clk); #1;
            chk({name, "_lat2"}, {31'd0, res_valid}, 32'd1);
            chk({name, "_z"}, {16'd0, res_z}, {16'd0, expz});
            chk({name, "_id"}, {30'd0, res_id}, {30'd0, id});
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic        ex;
        logic [15:0] z;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [15:0] held_z;
        logic [1:0]  held_id;

        vt[0] = '{"ff_ff_approx", 2'd2, 8'hFF, 8'hFF, 1'b0, 16'd64016};
        vt[1] = '{"0f_80_approx", 2'd1, 8'h0F, 8'h80, 1'b0, 16'd1792};
        vt[2] = '{"0f_80_exact",  2'd3, 8'h0F, 8'h80, 1'b1, 16'd1920};
        vt[3] = '{"ff_ff_exact",  2'd0, 8'hFF, 8'hFF, 1'b1, 16'd65025};
        vt[4] = '{"10_03_approx", 2'd2, 8'h10, 8'h03, 1'b0, 16'd48};
        vt[5] = '{"01_80_exact",  2'd0, 8'h01, 8'h80, 1'b1, 16'd128};
        vt[6] = '{"01_80_approx", 2'd1, 8'h01, 8'h80, 1'b0, 16'd256};

        // Reset state, with requests pending to prove ready stays low.
        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_z", {16'd0, res_z}, 32'd0);
        chk("rst_id", {30'd0, res_id}, 32'd0);
        chk("rst_count", {16'd0, op_count}, 32'd0);
        req_valid = 4'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Single-request vectors.
        for (int i = 0; i < 7; i++) begin
            run_one(vt[i].name, vt[i].id, vt[i].x, vt[i].y, vt[i].ex, vt[i].z);
        end

        // Backpressure: five stalled cycles inside a full-rate stream.
        idle(2);
        #1;
        req_valid = 4'hF;
        req_x = 32'h8142_C3F0;
        req_y = 32'h17E5_9A3C;
        cfg_exact = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        held_z  = res_z;
        held_id = res_id;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_held_z", {16'd0, res_z}, {16'd0, held_z});
        chk("bp_held_id", {30'd0, res_id}, {30'd0, held_id});
        res_ready = 1'b1;
        repeat (6) @(posedge clk);
        idle(4);

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom_range(0, 15));
            req_x     = $urandom;
            req_y     = $urandom;
            cfg_exact = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 9) < 7);
        end
        idle(0);
        for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);

        // Reset with both stages occupied.
        @(posedge clk); #1;
        req_valid = 4'b0011;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_full", {31'd0, res_valid}, 32'd1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("mid_rst_z", {16'd0, res_z}, 32'd0);
        chk("mid_rst_id", {30'd0, res_id}, 32'd0);
        chk("mid_rst_count", {16'd0, op_count}, 32'd0);
        chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        req_valid = 4'd0;
        res_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
        end
        exp_q.delete();
        mdl_rr    = 0;
        mdl_cnt   = 16'd0;
        hold_prev = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Fairness: all requesters valid from a fresh pointer.
        req_valid = 4'hF;
        req_x = 32'h0403_0201;
        req_y = 32'h0807_0605;
        cfg_exact = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("fair_grant", {28'd0, req_ready}, 32'(1 << (k % 4)));
        end
        idle(4);
        #1;
        chk("fair_count", {16'd0, op_count}, 32'd8);

        // Saturation from a preloaded counter.
        @(posedge clk); #2;
        force dut.op_count_r = 16'hFFFE;
        #1;
        release dut.op_count_r;
        mdl_cnt = 16'hFFFE;
        run_one("sat_a", 2'd0, 8'h03, 8'h05, 1'b1, 16'd15);
        run_one("sat_b", 2'd1, 8'h07, 8'h09, 1'b1, 16'd63);
        run_one("sat_c", 2'd3, 8'h0B, 8'h0D, 1'b1, 16'd143);
        idle(3);
        #1;
        chk("sat_count", {16'd0, op_count}, 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pam_mul_sched.md
PAM_MUL_SCHED -- requirements
Module: pam_mul_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (fixed at 4 in this revision).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 4 bits: per-requester operand valid.
REQ-005 SHALL have port req_ready, output, 4 bits: per-requester accept; one-hot or zero.
REQ-006 SHALL have port req_x, input, 32 bits: 8-bit multiplicand per requester; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port req_y, input, 32 bits: 8-bit multiplier per requester, same packing as req_x.
REQ-008 SHALL have port cfg_exact, input, 1 bit: 1 selects the exact product, 0 the approximate product; sampled with the operands.
REQ-009 SHALL have port res_valid, output, 1 bit: result valid.
REQ-010 SHALL have port res_ready, input, 1 bit: downstream accept.
REQ-011 SHALL have port res_z, output, 16 bits: product.
REQ-012 SHALL have port res_id, output, 2 bits: index of the requester that owns res_z.
REQ-013 SHALL have port op_count, output, 16 bits: number of completed results, saturating.

Function
REQ-014 SHALL transfer a request when req_valid[i] and req_ready[i] are both high on a clock edge; SHALL transfer a result when res_valid and res_ready are both high.
REQ-015 SHALL arbitrate round-robin: search starts at rr_ptr and moves upward modulo 4; the first valid requester wins.
REQ-016 SHALL set rr_ptr to (winner+1) mod 4 on each transfer; rr_ptr SHALL NOT change when no transfer occurs.
REQ-017 SHALL assert req_ready only for the winner, and only when stage 1 is empty or advancing this cycle.
REQ-018 SHALL use a 2-stage pipeline:
- S1 registers x, y, id and cfg_exact.
- S2 registers the product and id, which drive res_z and res_id.
- Latency from request transfer to res_valid is 2 cycles.
REQ-019 SHALL hold S2 while res_valid=1 and res_ready=0, and S1 SHALL stall behind it; no result is lost or duplicated.
REQ-020 SHALL sustain one transfer per cycle when res_ready is held high.
REQ-021 SHALL keep res_z and res_id stable while res_valid=1 and res_ready=0.
REQ-022 SHALL compute the approximate product as the sum of:
- (y*x[7:4])<<4;
- bit8 term: (x0&y7)|(x1&y6);
- bit9 term: (x2&y6)|(x3&y5);
- bit10 term: x3&y7;
- bit9 term: (x2&y7)&(x3&y6);
- bit9 term: (x2&y7)|(x3&y6).
The sum SHALL be taken modulo 2^16.
REQ-023 SHALL compute the exact product as x*y when cfg_exact=1.
REQ-024 SHALL increment op_count on each result transfer and hold it at 0xFFFF once reached.
REQ-025 SHALL treat a change of req_x or req_y while valid but not granted as a new operand, with no error.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear: req_ready=0, res_valid=0, res_z=0, res_id=0, op_count=0, rr_ptr=0, and both stage-valid bits.
REQ-027 SHALL discard in-flight operations when reset is asserted mid-operation; no result SHALL appear after release.
REQ-028 SHALL accept its first request no earlier than the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place the following in shared package pam_pkg: NREQ, ID_W=2, OP_W=8, PROD_W=16, and the cnt_sat_max constant.
REQ-030 SHALL instantiate exactly one combinational sub-module, pam_approx_mul8_l4 (inputs x, y, exact; output z[15:0]), implementing REQ-022 and REQ-023.
REQ-031 SHALL contain no latches; all outputs SHALL be registered except req_ready.

Verification
REQ-032 SHALL verify a single request: requester 2, x=0xFF, y=0xFF, cfg_exact=0 -> res_z=64016 (0xFA10), res_id=2, two cycles after the transfer.
REQ-033 SHALL verify the approximate and exact paths: x=0x0F, y=0x80 with cfg_exact=0 -> 1792; with cfg_exact=1 -> 1920.
REQ-034 SHALL verify fairness: all four requesters valid continuously, res_ready=1 -> grant order 0,1,2,3,0,...; op_count=8 after 8 results.
REQ-035 SHALL verify backpressure: res_ready=0 for 5 cycles during a stream -> res_z and res_id held; no drop or duplicate; in-order ids on release.
REQ-036 SHALL verify reset mid-operation: rst_n pulsed low with both stages full -> all outputs 0 immediately; no res_valid until a new request.
REQ-037 SHALL verify saturation: op_count preloaded to 0xFFFE by back-door force, then 3 results -> op_count=0xFFFF.
